// File: rtl/misr_response_compactor.sv
// Compacts one CUT response word per pattern into a Galois MISR. After num_pat
// responses it compares the signature with the golden value and reports pass/fail.
module misr_response_compactor #(
  parameter int                OUT_W = 1,
  parameter int                SIG_W = 16,
  parameter logic [SIG_W-1:0]  POLY  = 16'hB400,
  parameter logic [SIG_W-1:0]  SEED  = 16'h0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [15:0]      num_pat,
  input  logic [SIG_W-1:0] golden,
  input  logic             resp_valid,
  input  logic [OUT_W-1:0] resp,
  output logic [SIG_W-1:0] signature,
  output logic [15:0]      pat_count,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [1:0]       dbg_state
);

  // Handshake: resp is consumed on every rising edge where resp_valid=1 and
  // the block is in CAPTURE; there is no ready, so responses offered in any
  // other state (or past the programmed count) are dropped.

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    COMPARE = 2'd2,
    DONE    = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [15:0]      num_q, num_d;
  logic             pass_q, pass_d;
  logic [15:0]      cnt_inc;
  logic [SIG_W-1:0] sig_step;

  assign cnt_inc  = cnt_q + 16'd1;
  assign sig_step = {sig_q[SIG_W-2:0], 1'b0}
                  ^ (sig_q[SIG_W-1] ? POLY : '0)
                  ^ SIG_W'(resp);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sig_q   <= SEED;
      cnt_q   <= '0;
      num_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    pass_d  = pass_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          sig_d   = SEED;
          cnt_d   = '0;
          num_d   = num_pat;
          pass_d  = 1'b0;
          // An empty run skips capture and compares the seed directly.
          state_d = (num_pat != 16'd0) ? CAPTURE : COMPARE;
        end
      end
      CAPTURE: begin
        if (resp_valid) begin
          sig_d = sig_step;
          cnt_d = cnt_inc;
          if (cnt_inc == num_q) state_d = COMPARE;
        end
      end
      COMPARE: begin
        pass_d  = (sig_q == golden);
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign signature = sig_q;
  assign pat_count = cnt_q;
  assign busy      = (state_q == CAPTURE) || (state_q == COMPARE);
  assign done      = (state_q == DONE);
  assign pass      = pass_q;
  assign dbg_state = state_q;

endmodule
